mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one mux4 datapath between four valid/ready requesters.
- Sequences the mux `en`/`sel` controls: picks a winner, holds the grant until the winner's last beat is accepted (or a beat-limit watchdog fires), then re-arbitrates.
- Sits between four producer streams and a single downstream consumer.
- Output data comes from an instantiated mux4, so idle output equals DISABLED.

Parameters:
- WIDTH, 32, data width of every requester and of the output.
- DISABLED, 0, value driven on out_data while no grant is held; passed to mux4.
- MAX_BEATS, 16, maximum beats per grant before forced release. Legal range 1..65535.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  4  per-requester beat valid; bit n belongs to requester n.
- req_last  input  4  per-requester end-of-packet marker, qualified by req_valid.
- req_ready  output  4  per-requester beat accepted; at most one bit set.
- i0, i1, i2, i3  input  WIDTH  requester data 0..3.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream can accept.
- out_data  output  WIDTH  downstream data (mux4 o).
- out_last  output  1  downstream end-of-packet.
- grant  output  4  one-hot current owner; 0 when idle.
- busy  output  1  grant held.
- overrun  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset values (async on rst, for any state including mid-packet):
  - state=IDLE, grant=0, busy=0, overrun=0, beat_cnt=0.
  - Pointer set so requester 0 has highest priority.
  - out_valid=0, out_last=0, req_ready=0, out_data=DISABLED.
- States: IDLE, BUSY.
- IDLE:
  - mux en=0; out_valid=0; req_ready=0.
  - If any req_valid bit is set, the winner is the first set bit scanning from ptr upward, modulo 4.
  - Next edge: grant=onehot(winner), sel=winner, busy=1, beat_cnt=0, state=BUSY.
  - Arbitration latency is 1 cycle from req_valid to grant.
- BUSY, owner k:
  - mux en=1, sel=k.
  - out_valid=req_valid[k]; out_last=req_valid[k]&req_last[k].
  - req_ready[k]=out_ready; all other req_ready bits are 0.
  - out_data is combinational through mux4, with no data latency.
- Accepted beat: req_valid[k] & out_ready.
  - Each accepted beat increments beat_cnt (16-bit, never wraps, because release happens at MAX_BEATS).
- Release: on the edge after an accepted beat where req_last[k]=1, or where beat_cnt+1==MAX_BEATS.
  - state=IDLE, grant=0, busy=0, ptr=(k+1) mod 4.
  - Exactly one idle cycle separates grants (bubble is required).
- Watchdog: release caused by beat_cnt+1==MAX_BEATS with req_last[k]=0 → overrun=1 for exactly the next cycle.
  - If req_last=1 on that same beat, the release is normal and overrun stays 0.
- While BUSY, other requesters' req_valid are ignored; no preemption.
- Owner dropping req_valid mid-packet: grant is held indefinitely; beat_cnt does not advance.
- out_ready low: owner stalls, state unchanged.
- Requester data and last are required stable while valid & !ready (producer rule); the block does not register them.
- Simultaneous requests in IDLE: round-robin order only. A requester that is not granted keeps its request pending.
- X-safety: grant, req_ready and out_valid are never X after reset deasserts.

Decomposition:
- Package mux4_arb_pkg:
  - typedef state_t {IDLE, BUSY}.
  - localparam NREQ=4.
  - typedef idx_t = logic [1:0].
  - function rr_pick(req[3:0], ptr) → idx_t.
- One sub-module: an instance of the existing mux4 (WIDTH, DISABLED) driven by en=busy and sel=owner index. No other sub-modules.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, no req → grant=0, out_valid=0, out_data=DISABLED (0), req_ready=0.
- Single packet: req_valid=4'b0100, 3 beats with i2=0xA,0xB,0xC, last on 3rd, out_ready=1.
  - grant=4'b0100 one cycle after req.
  - out_data 0xA,0xB,0xC on consecutive cycles; out_last on 0xC.
  - grant=0 the next cycle.
- Round-robin fairness: req_valid=4'b1111 constantly, 1-beat packets, out_ready=1 → grant sequence 0,1,2,3,0 with one idle cycle between grants.
- Backpressure: owner 1, out_ready=0 for 5 cycles mid-packet.
  - req_ready[1]=0, out_data stable at i1, beat_cnt frozen, grant unchanged.
  - Resumes on out_ready=1.
- Watchdog: MAX_BEATS=4, owner 3 streams 6 beats with req_last=0.
  - Release after the 4th accepted beat; overrun=1 for one cycle; next grant goes to requester 0 if requesting.
  - With req_last=1 on beat 4: overrun=0.
- Reset mid-packet: rst asserted asynchronously during BUSY with owner 2 → grant=0, out_valid=0, out_data=DISABLED immediately. After release, req_valid=4'b0110 grants requester 1 (pointer reset).

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the round-robin, packet-locked mux4 arbiter.
// Holds the FSM state encoding, requester index type and the priority scan.
package mux4_arb_pkg;

    localparam int NREQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [1:0] idx_t;

    // First set request bit scanning upward from ptr, wrapping modulo NREQ.
    // Returns ptr when nothing is requested; callers gate on |req.
    function automatic idx_t rr_pick(input logic [NREQ-1:0] req, input idx_t ptr);
        idx_t pick;
        idx_t cand;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + idx_t'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input idx_t idx);
        logic [NREQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux4.sv
// Four-input data mux with an enable; drives DISABLED whenever en is low.
module mux4 #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] DISABLED = '0
) (
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [WIDTH-1:0] o
);

    always_comb begin
        o = DISABLED;
        if (en) begin
            case (sel)
                2'd0:    o = i0;
                2'd1:    o = i1;
                2'd2:    o = i2;
                default: o = i3;
            endcase
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4 between four valid/ready producers.
// A grant is locked until the owner's last beat is accepted or MAX_BEATS elapse.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] DISABLED  = '0,
    parameter int               MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req_valid,
    input  logic [3:0]       req_last,
    output logic [3:0]       req_ready,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic [3:0]       grant,
    output logic             busy,
    output logic             overrun
);

    // Handshake: a beat moves when the owner's req_valid and out_ready are both
    // high on a rising edge; req_ready mirrors out_ready for the owner only.

    localparam logic [16:0] MAX_CNT = 17'(MAX_BEATS);

    state_t      state;
    idx_t        ptr;
    idx_t        owner;
    logic [15:0] beat_cnt;

    logic own_valid;
    logic own_last;
    logic accept;
    logic cnt_hit;
    logic release_now;
    idx_t winner;

    always_comb begin
        own_valid   = req_valid[owner];
        own_last    = req_last[owner];
        accept      = busy & own_valid & out_ready;
        cnt_hit     = (({1'b0, beat_cnt} + 17'd1) == MAX_CNT);
        release_now = accept & (own_last | cnt_hit);
        winner      = rr_pick(req_valid, ptr);
    end

    always_comb begin
        out_valid = busy & own_valid;
        out_last  = busy & own_valid & own_last;
        req_ready = '0;
        if (busy && out_ready) begin
            req_ready = onehot(owner);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        state    <= BUSY;
                        owner    <= winner;
                        grant    <= onehot(winner);
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        state    <= IDLE;
                        grant    <= '0;
                        busy     <= 1'b0;
                        beat_cnt <= '0;
                        ptr      <= owner + 2'd1;
                        // A last beat landing on the limit is a normal release.
                        overrun  <= cnt_hit & ~own_last;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    mux4 #(
        .WIDTH    (WIDTH),
        .DISABLED (DISABLED)
    ) u_mux4 (
        .en  (busy),
        .sel (owner),
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .i3  (i3),
        .o   (out_data)
    );

endmodule
